// File: rtl/bcs_pkg.sv
// -----------------------------------------------------------------------------
// bcs_pkg
// Shared definitions for the bit-comparator-slice (BCS) magnitude comparator.
//
// Contents:
//   BCS_MAX_WIDTH  - widest legal operand width for my_bcs
//   bcs_cascade_t  - the {equal, greater} cascade pair carried between slices
//   bcs_step()     - one-bit cascade update, returns {e', g'}
// -----------------------------------------------------------------------------
package bcs_pkg;

    localparam int BCS_MAX_WIDTH = 64;

    // Cascade pair as carried between slices and held in the output register.
    typedef struct packed {
        logic e;   // all more-significant bits so far are equal
        logic g;   // A already greater at a more-significant position
    } bcs_cascade_t;

    // One slice of the comparison, MSB-first.
    //   e' = e & ~(a ^ b)
    //   g' = g | (e & a & ~b)
    // A set g is sticky. A cleared e means a decision has already been made
    // upstream, so lower bits can no longer change the result.
    function automatic logic [1:0] bcs_step(
        input logic e,
        input logic g,
        input logic a,
        input logic b
    );
        logic e_next;
        logic g_next;
        e_next   = e & ~(a ^ b);
        g_next   = g | (e & a & ~b);
        bcs_step = {e_next, g_next};
    endfunction

endpackage

// File: rtl/bcs_slice.sv
// -----------------------------------------------------------------------------
// bcs_slice
// Combinational single-bit comparator cell. It continues the equal/greater
// cascade by one bit position.
//
// Ports:
//   a, b    in   operand bits at this position
//   e_in    in   cascade in: equal so far
//   g_in    in   cascade in: greater so far
//   e_out   out  cascade out: equal through this bit
//   g_out   out  cascade out: greater through this bit
// -----------------------------------------------------------------------------
module bcs_slice
    import bcs_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic e_in,
    input  logic g_in,
    output logic e_out,
    output logic g_out
);

    logic [1:0] step_res;

    always_comb begin
        step_res = bcs_step(e_in, g_in, a, b);
    end

    assign e_out = step_res[1];
    assign g_out = step_res[0];

endmodule

// File: rtl/my_bcs.sv
// -----------------------------------------------------------------------------
// my_bcs
// Magnitude comparator stage for building wide comparators. It compares two
// unsigned WIDTH-bit operands MSB to LSB and continues an incoming
// equal/greater cascade. The result is registered, so each stage adds exactly
// one cycle. Stages chain e1 -> e0 and g1 -> g0.
//
// Parameters:
//   WIDTH   number of bit slices, 1..BCS_MAX_WIDTH
//
// Ports:
//   clk     in   system clock, outputs update on the rising edge
//   rst_n   in   asynchronous active-low reset, clears e1/g1 at once
//   a0      in   operand A [WIDTH-1:0], unsigned, bit WIDTH-1 most significant
//   b0      in   operand B [WIDTH-1:0], unsigned
//   e0      in   cascade in: more-significant bits equal so far
//   g0      in   cascade in: A greater at a more-significant position
//   e1      out  registered cascade out: equal through this block
//   g1      out  registered cascade out: A greater through this block
//
// Flow: there is no handshake and no enable. A new operand set is sampled on
// every rising edge, and e1/g1 always show the result for the set sampled on
// the previous edge. "Less" is ~e1 & ~g1. The input e0=1, g0=1 is not
// rejected; it passes through the same equations.
// -----------------------------------------------------------------------------
module my_bcs
    import bcs_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             e0,
    input  logic             g0,
    output logic             e1,
    output logic             g1
);

    // Catch an out-of-range width at elaboration rather than building a
    // zero-length or oversized chain.
    if (WIDTH < 1 || WIDTH > BCS_MAX_WIDTH) begin : g_width_check
        $error("my_bcs: WIDTH must be in 1..%0d", BCS_MAX_WIDTH);
    end

    // Ripple chain. Index WIDTH is the cascade input. Index i is the cascade
    // after slice i has been applied, so index 0 is the full result.
    logic [WIDTH:0] e_chain;
    logic [WIDTH:0] g_chain;

    assign e_chain[WIDTH] = e0;
    assign g_chain[WIDTH] = g0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        bcs_slice u_slice (
            .a     (a0[i]),
            .b     (b0[i]),
            .e_in  (e_chain[i+1]),
            .g_in  (g_chain[i+1]),
            .e_out (e_chain[i]),
            .g_out (g_chain[i])
        );
    end

    // Output register.
    bcs_cascade_t cascade_d;
    bcs_cascade_t cascade_q;

    always_comb begin
        cascade_d   = '0;
        cascade_d.e = e_chain[0];
        cascade_d.g = g_chain[0];
    end

    // The reset drops the outputs immediately and discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cascade_q <= '0;
        end else begin
            cascade_q <= cascade_d;
        end
    end

    assign e1 = cascade_q.e;
    assign g1 = cascade_q.g;

endmodule

// File: tb/tb_my_bcs.sv
// -----------------------------------------------------------------------------
// tb_my_bcs
// Directed bench for my_bcs. It covers a WIDTH=1 instance, a WIDTH=4 instance,
// and two WIDTH=4 instances chained into an 8-bit comparator.
// -----------------------------------------------------------------------------
module tb_my_bcs;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       a1_a, a1_b, a1_e, a1_g;
    logic       a1_e1, a1_g1;

    logic [3:0] w4_a, w4_b;
    logic       w4_e, w4_g;
    logic       w4_e1, w4_g1;

    logic [3:0] hi_a, hi_b, lo_a, lo_b;
    logic [3:0] lo_a_q, lo_b_q;
    logic       hi_e1, hi_g1;
    logic       ch_e1, ch_g1;

    my_bcs #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .a0(a1_a), .b0(a1_b), .e0(a1_e), .g0(a1_g),
        .e1(a1_e1), .g1(a1_g1)
    );

    my_bcs #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .a0(w4_a), .b0(w4_b), .e0(w4_e), .g0(w4_g),
        .e1(w4_e1), .g1(w4_g1)
    );

    // Upper nibble stage. Its registered outputs feed the lower stage.
    my_bcs #(.WIDTH(4)) u_hi (
        .clk(clk), .rst_n(rst_n),
        .a0(hi_a), .b0(hi_b), .e0(1'b1), .g0(1'b0),
        .e1(hi_e1), .g1(hi_g1)
    );

    // The lower operands are delayed one cycle to line up with hi_e1/hi_g1.
    always @(posedge clk) begin
        lo_a_q <= lo_a;
        lo_b_q <= lo_b;
    end

    my_bcs #(.WIDTH(4)) u_lo (
        .clk(clk), .rst_n(rst_n),
        .a0(lo_a_q), .b0(lo_b_q), .e0(hi_e1), .g0(hi_g1),
        .e1(ch_e1), .g1(ch_g1)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got e1g1=%b expected e1g1=%b", name, act, expv);
        end
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic       a;
        logic       b;
        logic       e;
        logic       g;
        logic [1:0] expv;   // {e1, g1}
    } vec1_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       e;
        logic       g;
        logic [1:0] expv;
    } vec4_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] expv;
    } vec8_t;

    vec1_t t1[16];
    vec4_t t4[10];
    vec8_t t8[4];

    // ---------------- driver tasks ----------------
    task automatic drive_w1(input vec1_t v);
        a1_a = v.a; a1_b = v.b; a1_e = v.e; a1_g = v.g;
    endtask

    task automatic drive_w4(input vec4_t v);
        w4_a = v.a; w4_b = v.b; w4_e = v.e; w4_g = v.g;
    endtask

    // ---------------- test body ----------------
    initial begin
        logic [1:0] prev;
        string nm;

        // WIDTH=1 exhaustive, hand-computed {e1,g1}. Order is {a,b,e,g}.
        t1[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        t1[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        t1[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
        t1[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11};
        t1[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        t1[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01};
        t1[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
        t1[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01};
        t1[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        t1[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
        t1[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
        t1[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01};
        t1[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        t1[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
        t1[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
        t1[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11};

        // WIDTH=4. Consecutive entries alternate results to catch lag/bubbles.
        t4[0] = '{4'b1010, 4'b1001, 1'b1, 1'b0, 2'b01};
        t4[1] = '{4'b0111, 4'b1000, 1'b1, 1'b0, 2'b00};
        t4[2] = '{4'b1100, 4'b1100, 1'b1, 1'b0, 2'b10};
        t4[3] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'b01};
        t4[4] = '{4'b0001, 4'b0010, 1'b1, 1'b0, 2'b00};
        t4[5] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'b10};
        t4[6] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 2'b00};
        t4[7] = '{4'b0011, 4'b1111, 1'b0, 1'b1, 2'b01};
        t4[8] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'b11};
        t4[9] = '{4'b1000, 4'b0111, 1'b1, 1'b0, 2'b01};

        // Chained 8-bit comparisons.
        t8[0] = '{8'hA5, 8'hA3, 2'b01};
        t8[1] = '{8'h5A, 8'h5A, 2'b10};
        t8[2] = '{8'h3F, 8'h40, 2'b00};
        t8[3] = '{8'hB0, 8'hAF, 2'b01};

        // ---- reset: outputs clear without a clock edge ----
        rst_n = 1'b0;
        a1_a = 1'b1; a1_b = 1'b0; a1_e = 1'b1; a1_g = 1'b1;
        w4_a = 4'hF; w4_b = 4'h0; w4_e = 1'b1; w4_g = 1'b1;
        hi_a = 4'h0; hi_b = 4'h0; lo_a = 4'h0; lo_b = 4'h0;
        #2;
        check("reset_w1", {a1_e1, a1_g1}, 2'b00);
        check("reset_w4", {w4_e1, w4_g1}, 2'b00);
        check("reset_chain", {ch_e1, ch_g1}, 2'b00);

        // Release between edges, then present 1 vs 1 with e0=1, g0=0.
        @(posedge clk); #1;
        rst_n = 1'b1;
        a1_a = 1'b1; a1_b = 1'b1; a1_e = 1'b1; a1_g = 1'b0;
        #2;
        check("release_hold_w1", {a1_e1, a1_g1}, 2'b00);
        @(posedge clk); #1;
        check("release_first_w1", {a1_e1, a1_g1}, 2'b10);

        // ---- WIDTH=1 exhaustive, one vector per cycle ----
        // Before each edge the previous result must still be held; after the
        // edge the new one must appear.
        prev = 2'b10;
        for (int i = 0; i < 16; i++) begin
            drive_w1(t1[i]);
            #3;
            nm = $sformatf("w1_hold_%0d", i);
            check(nm, {a1_e1, a1_g1}, prev);
            @(posedge clk); #1;
            nm = $sformatf("w1_vec_%0d", i);
            check(nm, {a1_e1, a1_g1}, t1[i].expv);
            prev = t1[i].expv;
        end

        // ---- WIDTH=4 back-to-back ----
        // exp_q holds the result expected after the next edge.
        for (int i = 0; i < 10; i++) begin
            drive_w4(t4[i]);
            exp_q.push_back(t4[i].expv);
            @(posedge clk); #1;
            nm = $sformatf("w4_vec_%0d", i);
            check(nm, {w4_e1, w4_g1}, exp_q.pop_front());
        end

        // ---- mid-stream reset while e1=1 ----
        drive_w1(t1[14]);                    // 1 vs 1, e=1 -> e1=1
        @(posedge clk); #1;
        check("mid_pre_w1", {a1_e1, a1_g1}, 2'b10);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_drop_w1", {a1_e1, a1_g1}, 2'b00);
        @(posedge clk); #1;
        check("mid_held_w1", {a1_e1, a1_g1}, 2'b00);
        rst_n = 1'b1;
        #3;
        check("mid_release_w1", {a1_e1, a1_g1}, 2'b00);
        @(posedge clk); #1;
        check("mid_resume_w1", {a1_e1, a1_g1}, 2'b10);

        // ---- two chained WIDTH=4 blocks ----
        // Each vector is held two edges: one for the upper stage and one for
        // the lower stage.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] va;
            logic [7:0] vb;
            va = t8[i].a;
            vb = t8[i].b;
            hi_a = va[7:4]; hi_b = vb[7:4];
            lo_a = va[3:0]; lo_b = vb[3:0];
            @(posedge clk);
            @(posedge clk); #1;
            nm = $sformatf("chain_%0d", i);
            check(nm, {ch_e1, ch_g1}, t8[i].expv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
